scanline_irq_ctrl: RTL and testbench
====================================

SCANLINE_IRQ_CTRL -- requirements
Module: scanline_irq_ctrl

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 3: minimum count of consecutive m2 cycles with synchronized A12 low before a rising edge qualifies.
REQ-002 The block SHALL have port m2, input, 1 bit: the single clock; all state updates on the rising edge of m2.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of m2.
REQ-004 The block SHALL have port ppu_a12, input, 1 bit: raw PPU address bit 12, asynchronous to m2.
REQ-005 The block SHALL have port reg_we, input, 1 bit: one-cycle write strobe, already decoded by the mapper.
REQ-006 The block SHALL have port reg_sel, input, 2 bits: 0 = latch, 1 = reload, 2 = disable/ack, 3 = enable.
REQ-007 The block SHALL have port reg_data, input, 8 bits: write data; used only for reg_sel=0.
REQ-008 The block SHALL have port irq, output, 1 bit: active-low IRQ; 0 = asserted.
REQ-009 The block SHALL have port irq_counter, output, 8 bits: current counter value, for debug readback.

Function
REQ-010 ppu_a12 SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized value for edge detection.
REQ-011 The low-time counter SHALL increment each cycle the synchronized A12 is 0, saturate at FILTER_LEN, and clear each cycle it is 1.
REQ-012 A qualified edge SHALL be synchronized A12 0->1 with the low-time counter equal to FILTER_LEN in the same cycle; shorter low pulses SHALL be ignored.
REQ-013 reg_we with reg_sel=0 SHALL load the latch from reg_data.
REQ-014 reg_we with reg_sel=1 SHALL set reload_flag; the counter value SHALL NOT change.
REQ-015 reg_we with reg_sel=2 SHALL clear irq_enable and clear the pending IRQ.
REQ-016 reg_we with reg_sel=3 SHALL set irq_enable; the pending state SHALL be unchanged.
REQ-017 On a qualified edge, if counter==0 or reload_flag=1, counter SHALL load from latch and reload_flag SHALL clear; otherwise counter SHALL decrement by 1, 8-bit, with no wrap possible.
REQ-018 On a qualified edge, if the next counter value is 0 and irq_enable=1, pending SHALL set one cycle after the edge (default behaviour; see REQ-026).
REQ-019 irq SHALL equal ~pending, registered; worst-case latency SHALL be 4 m2 cycles from the ppu_a12 transition to irq falling: 2 sync + 1 edge + 1 pending.
REQ-020 Pending SHALL remain set until reg_sel=2 or reset.
REQ-021 reload write in the same cycle as a qualified edge: the edge SHALL treat reload_flag as set, loading the latch.
REQ-022 latch write in the same cycle as a qualified edge: the edge SHALL use the old latch value.
REQ-023 disable in the same cycle as a pending-set condition: disable SHALL win, and pending SHALL stay 0.
REQ-024 latch=0 with irq_enable=1: every qualified edge SHALL set pending (default build).

Reset
REQ-025 reset=1 SHALL force on the next m2 edge: counter=0, latch=0, reload_flag=0, irq_enable=0, pending=0, irq=1, low-time counter=0, synchronizer flops=0; reset mid-count SHALL abandon all state with no IRQ emitted.

Configuration
REQ-026 Macro SCANLINE_IRQ_REV_A_EN SHALL select between two behaviours.
  - Defined: pending SHALL set only when the counter decrements from 1 to 0, or when it is reloaded to 0 because reload_flag=1.
  - Undefined: pending SHALL set whenever the post-edge counter is 0 (REQ-018, REQ-024).

Verification
REQ-027 Scenario 1:
  - Stimulus: reset; latch=3; reload; enable; 4 A12 pulses, each low 5 cycles.
  - Required: counter 3,2,1,0; irq falls after the 4th pulse, within 4 cycles.
REQ-028 Scenario 2:
  - Stimulus: A12 low pulses of 2 cycles, FILTER_LEN=3.
  - Required: counter unchanged; irq stays 1.
REQ-029 Scenario 3:
  - Stimulus: irq asserted; write reg_sel=2.
  - Required: irq=1 the next cycle; a further edge reaching 0 gives no IRQ until reg_sel=3 is written.
REQ-030 Scenario 4:
  - Stimulus: reload write coincident with a qualified edge, counter=5, latch=9.
  - Required: counter=9.
REQ-031 Scenario 5:
  - Stimulus: latch=0, enabled, one edge.
  - Required: irq asserted in the default build; not asserted with SCANLINE_IRQ_REV_A_EN defined, unless reload_flag was set.
REQ-032 Scenario 6:
  - Stimulus: reset asserted while counter=2 and pending=1.
  - Required: irq=1, counter=0 the next cycle.

Source files
------------

// File: rtl/scanline_irq_ctrl.sv
// Scanline IRQ counter clocked by m2: synchronised, low-time filtered PPU A12 edges clock an
// 8-bit reloadable down-counter. Define SCANLINE_IRQ_REV_A_EN for the revision-A pending rule.
module scanline_irq_ctrl #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       ppu_a12,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_data,
    output logic       irq,
    output logic [7:0] irq_counter
);
    localparam int unsigned LW = $clog2(FILTER_LEN + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(FILTER_LEN);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_a12_prev;
    logic [LW-1:0] r_low_cnt;
    logic [7:0]    r_counter;
    logic [7:0]    r_latch;
    logic          r_reload;
    logic          r_enable;
    logic          r_pending;
    logic          r_irq;

    logic [LW-1:0] w_low_cnt_d;
    logic [7:0]    w_counter_d;
    logic [7:0]    w_latch_d;
    logic          w_reload_d;
    logic          w_enable_d;
    logic          w_pending_d;
    logic          w_edge;
    logic          w_wr_latch;
    logic          w_wr_reload;
    logic          w_wr_disable;
    logic          w_wr_enable;
    logic          w_reload_eff;
    logic          w_load;
    logic          w_set;

    always_comb begin
        w_wr_latch   = reg_we && (reg_sel == 2'd0);
        w_wr_reload  = reg_we && (reg_sel == 2'd1);
        w_wr_disable = reg_we && (reg_sel == 2'd2);
        w_wr_enable  = reg_we && (reg_sel == 2'd3);

        // Low-time filter: only edges preceded by FILTER_LEN low cycles count.
        w_low_cnt_d = r_low_cnt;
        if (r_sync2) begin
            w_low_cnt_d = '0;
        end else if (r_low_cnt != LOW_MAX) begin
            w_low_cnt_d = r_low_cnt + 1'b1;
        end
        w_edge = r_sync2 && !r_a12_prev && (r_low_cnt == LOW_MAX);

        // A reload strobe coincident with an edge is honoured by that edge.
        w_reload_eff = r_reload || w_wr_reload;
        w_load       = (r_counter == 8'd0) || w_reload_eff;

        w_counter_d = r_counter;
        w_reload_d  = w_reload_eff;
        w_set       = 1'b0;
        if (w_edge) begin
            w_reload_d = 1'b0;
            if (w_load) begin
                w_counter_d = r_latch;
            end else begin
                w_counter_d = r_counter - 8'd1;
            end
`ifdef SCANLINE_IRQ_REV_A_EN
            w_set = r_enable && (w_load ? (w_reload_eff && (r_latch == 8'd0))
                                        : (r_counter == 8'd1));
`else
            w_set = r_enable && (w_counter_d == 8'd0);
`endif
        end

        w_latch_d = w_wr_latch ? reg_data : r_latch;

        w_enable_d = r_enable;
        if (w_wr_disable) begin
            w_enable_d = 1'b0;
        end else if (w_wr_enable) begin
            w_enable_d = 1'b1;
        end

        // Acknowledge beats a simultaneous set.
        w_pending_d = w_wr_disable ? 1'b0 : (r_pending || w_set);
    end

    always_ff @(posedge m2) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_a12_prev <= 1'b0;
            r_low_cnt  <= '0;
            r_counter  <= 8'd0;
            r_latch    <= 8'd0;
            r_reload   <= 1'b0;
            r_enable   <= 1'b0;
            r_pending  <= 1'b0;
            r_irq      <= 1'b1;
        end else begin
            r_sync1    <= ppu_a12;
            r_sync2    <= r_sync1;
            r_a12_prev <= r_sync2;
            r_low_cnt  <= w_low_cnt_d;
            r_counter  <= w_counter_d;
            r_latch    <= w_latch_d;
            r_reload   <= w_reload_d;
            r_enable   <= w_enable_d;
            r_pending  <= w_pending_d;
            r_irq      <= ~w_pending_d;
        end
    end

    assign irq         = r_irq;
    assign irq_counter = r_counter;

endmodule

// File: tb/tb_scanline_irq_ctrl.sv
// Self-checking bench for scanline_irq_ctrl: vector table, corner-case sequences and random
// stimulus against a sample-history reference model.
module tb_scanline_irq_ctrl;
    localparam int unsigned F = 3;

    logic       m2 = 1'b0;
    logic       reset = 1'b0;
    logic       ppu_a12 = 1'b1;
    logic       reg_we = 1'b0;
    logic [1:0] reg_sel = 2'd0;
    logic [7:0] reg_data = 8'd0;
    logic       irq;
    logic [7:0] irq_counter;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: raw A12 samples plus architectural register values.
    int hist[$];
    int m_cnt = 0;
    int m_latch = 0;
    bit m_reload = 0;
    bit m_en = 0;
    bit m_pend = 0;

    always #5 m2 = ~m2;

    scanline_irq_ctrl #(.FILTER_LEN(F)) dut (
        .m2          (m2),
        .reset       (reset),
        .ppu_a12     (ppu_a12),
        .reg_we      (reg_we),
        .reg_sel     (reg_sel),
        .reg_data    (reg_data),
        .irq         (irq),
        .irq_counter (irq_counter)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample s[n-2] is what the edge logic sees at edge n; it qualifies when it is 1 and the F
    // samples before it are all 0. Value 2 marks a reset boundary that breaks a low run.
    function automatic void model_step(bit r, bit a, bit we, logic [1:0] sel, logic [7:0] d);
        bit q;
        bit rel;
        bit loaded;
        bit set;
        int sz;
        if (r) begin
            m_cnt = 0; m_latch = 0; m_reload = 0; m_en = 0; m_pend = 0;
            hist.delete();
            hist.push_back(2); hist.push_back(0); hist.push_back(0);
            return;
        end
        hist.push_back(int'(a));
        while (hist.size() > F + 3) void'(hist.pop_front());
        sz = hist.size();
        q = 0;
        if (sz >= F + 3 && hist[sz-3] == 1) begin
            q = 1;
            for (int i = 1; i <= F; i++) if (hist[sz-3-i] != 0) q = 0;
        end
        rel = m_reload || (we && sel == 2'd1);
        loaded = 0;
        set = 0;
        if (q) begin
            if (m_cnt == 0 || rel) begin
                loaded = 1;
                m_cnt = m_latch;
            end else begin
                m_cnt = m_cnt - 1;
            end
`ifdef SCANLINE_IRQ_REV_A_EN
            set = m_en && (loaded ? (rel && m_latch == 0) : (m_cnt == 0));
`else
            set = m_en && (m_cnt == 0);
`endif
            m_reload = 0;
        end else begin
            m_reload = rel;
        end
        if (we && sel == 2'd2) m_pend = 0;
        else if (set) m_pend = 1;
        if (we && sel == 2'd0) m_latch = int'(d);
        if (we && sel == 2'd2) m_en = 0;
        if (we && sel == 2'd3) m_en = 1;
    endfunction

    task automatic step();
        bit r = reset;
        bit a = ppu_a12;
        bit we = reg_we;
        logic [1:0] s = reg_sel;
        logic [7:0] d = reg_data;
        @(posedge m2);
        #1;
        model_step(r, a, we, s, d);
        check("cyc_irq", {31'd0, irq}, {31'd0, !m_pend});
        check("cyc_cnt", {24'd0, irq_counter}, m_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        reg_we = 1'b1; reg_sel = sel; reg_data = d;
        step();
        reg_we = 1'b0;
    endtask

    task automatic pulse(input int low);
        ppu_a12 = 1'b0;
        repeat (low) step();
        ppu_a12 = 1'b1;
        repeat (6) step();
    endtask

    // Qualified edge lands on the third edge after A12 is raised; strobe a write into it.
    task automatic edge_with_write(input logic [1:0] sel, input logic [7:0] d);
        ppu_a12 = 1'b0;
        repeat (5) step();
        ppu_a12 = 1'b1;
        step();
        step();
        wr(sel, d);
        repeat (4) step();
    endtask

    typedef struct {
        bit         do_wr;
        logic [1:0] sel;
        logic [7:0] data;
        int         low_len;
        int         pulses;
        logic [7:0] exp_cnt;
        logic       exp_irq;
        string      name;
    } vec_t;

    function automatic vec_t mk(bit w, logic [1:0] s, logic [7:0] d, int l, int p,
                                logic [7:0] c, logic i, string n);
        vec_t v;
        v.do_wr = w; v.sel = s; v.data = d; v.low_len = l; v.pulses = p;
        v.exp_cnt = c; v.exp_irq = i; v.name = n;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int lat;
        int run;

        vecs.push_back(mk(1, 2'd0, 8'd3, 0, 0, 8'd0, 1'b1, "latch3"));
        vecs.push_back(mk(1, 2'd1, 8'd0, 0, 0, 8'd0, 1'b1, "reload"));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 8'd0, 1'b1, "enable"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 5, 1, 8'd3, 1'b1, "edge1"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 5, 1, 8'd2, 1'b1, "edge2"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 2, 3, 8'd2, 1'b1, "short_pulses"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 3, 1, 8'd1, 1'b1, "exact_len"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 5, 1, 8'd0, 1'b0, "reach_zero"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 2, 2, 8'd0, 1'b0, "pend_holds"));
        vecs.push_back(mk(1, 2'd2, 8'd0, 0, 0, 8'd0, 1'b1, "disable_ack"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 5, 1, 8'd3, 1'b1, "dis_reload"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 5, 3, 8'd0, 1'b1, "dis_zero"));
        vecs.push_back(mk(1, 2'd3, 8'd0, 0, 0, 8'd0, 1'b1, "reenable"));
        vecs.push_back(mk(0, 2'd0, 8'd0, 5, 1, 8'd3, 1'b1, "after_en"));

        hist.push_back(2); hist.push_back(0); hist.push_back(0);
        do_reset();
        check("reset_irq", {31'd0, irq}, 32'd1);
        check("reset_cnt", {24'd0, irq_counter}, 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].do_wr) wr(vecs[k].sel, vecs[k].data);
            for (int p = 0; p < vecs[k].pulses; p++) pulse(vecs[k].low_len);
            step();
            check({"vec_cnt_", vecs[k].name}, {24'd0, irq_counter}, {24'd0, vecs[k].exp_cnt});
            check({"vec_irq_", vecs[k].name}, {31'd0, irq}, {31'd0, vecs[k].exp_irq});
        end

        // Latency of the fourth edge from the raw A12 rise to irq falling.
        do_reset();
        wr(2'd0, 8'd3); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
        repeat (3) pulse(5);
        ppu_a12 = 1'b0;
        repeat (5) step();
        ppu_a12 = 1'b1;
        lat = 0;
        while (irq !== 1'b0 && lat < 8) begin
            step();
            lat++;
        end
        check("latency_irq", {31'd0, irq}, 32'd0);
        check("latency_le4", {31'd0, (lat <= 4)}, 32'd1);
        repeat (4) step();

        // Reload coincident with edge loads latch; latch write coincident uses old latch.
        do_reset();
        wr(2'd0, 8'd5); wr(2'd1, 8'd0);
        pulse(5);
        check("s4_cnt5", {24'd0, irq_counter}, 32'd5);
        wr(2'd0, 8'd9);
        edge_with_write(2'd1, 8'd0);
        check("s4_reload_coinc", {24'd0, irq_counter}, 32'd9);
        wr(2'd1, 8'd0);
        edge_with_write(2'd0, 8'd4);
        check("latch_coinc_old", {24'd0, irq_counter}, 32'd9);
        wr(2'd1, 8'd0);
        pulse(5);
        check("latch_coinc_new", {24'd0, irq_counter}, 32'd4);

        // Disable coincident with the pending-set edge.
        do_reset();
        wr(2'd0, 8'd1); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
        pulse(5);
        edge_with_write(2'd2, 8'd0);
        check("dis_coinc_cnt", {24'd0, irq_counter}, 32'd0);
        check("dis_coinc_irq", {31'd0, irq}, 32'd1);

        // latch=0, enabled, single edge.
        do_reset();
        wr(2'd3, 8'd0);
        pulse(5);
`ifdef SCANLINE_IRQ_REV_A_EN
        check("latch0_irq", {31'd0, irq}, 32'd1);
`else
        check("latch0_irq", {31'd0, irq}, 32'd0);
`endif
        do_reset();
        wr(2'd1, 8'd0); wr(2'd3, 8'd0);
        pulse(5);
        check("latch0_reload_irq", {31'd0, irq}, 32'd0);

        // Reset with counter=2 and pending set, then reset mid-count.
        do_reset();
        wr(2'd0, 8'd1); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
        pulse(5);
        pulse(5);
        wr(2'd0, 8'd2);
        pulse(5);
        check("s6_pre_cnt", {24'd0, irq_counter}, 32'd2);
        check("s6_pre_irq", {31'd0, irq}, 32'd0);
        do_reset();
        check("s6_irq", {31'd0, irq}, 32'd1);
        check("s6_cnt", {24'd0, irq_counter}, 32'd0);
        wr(2'd0, 8'd1); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
        pulse(5);
        ppu_a12 = 1'b0;
        repeat (5) step();
        ppu_a12 = 1'b1;
        step();
        do_reset();
        repeat (6) step();
        check("midreset_irq", {31'd0, irq}, 32'd1);
        check("midreset_cnt", {24'd0, irq_counter}, 32'd0);

        // Random A12 runs, register writes and occasional resets.
        do_reset();
        wr(2'd3, 8'd0);
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                ppu_a12 = ~ppu_a12;
                run = ppu_a12 ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 6));
            end
            run--;
            reg_we = ($urandom_range(0, 11) == 0);
            reg_sel = 2'($urandom_range(0, 3));
            reg_data = 8'($urandom_range(0, 4));
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reg_we = 1'b0;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
